// File: rtl/display_scan_out.sv
// ============================================================================
// Module   : display_scan_out
// Brief    : Frame-buffer scan-out; generates blank/active timing, issues one
//            read per active pixel and presents returned pixels with flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_out #(
    parameter int ADDR_W     = 16,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        HBOut_PD,
    input  logic [9:0]        VBOut_PD,
    input  logic [9:0]        AIPOut_PD,
    input  logic [9:0]        AILOut_PD,
    output logic              FrameRd,
    output logic [ADDR_W-1:0] FrameRAddr,
    input  logic [7:0]        FrameRData,
    output logic [7:0]        PixOut,
    output logic              PixValid,
    output logic              HBlank,
    output logic              VBlank,
    output logic              LineStart,
    output logic              FrameDone,
    output logic              Busy,
    output logic              CfgErr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VBLANK = 2'd1,
        S_HBLANK = 2'd2,
        S_ACTIVE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [9:0]        r_pix_cnt;
    logic [9:0]        w_pix_cnt_nxt;
    logic [9:0]        r_line_cnt;
    logic [9:0]        w_line_cnt_nxt;
    logic              r_vb_act;
    logic              w_vb_act_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [9:0]        r_hb;
    logic [9:0]        r_vb;
    logic [9:0]        r_aip;
    logic [9:0]        r_ail;
    logic              w_latch;
    logic              w_cfg_err;
    logic              w_frame_end;
    logic [9:0]        w_seg_last;

    logic              r_pix_valid;
    logic              r_hblank;
    logic              r_vblank;
    logic              r_line_start;
    logic              r_frame_done;
    logic              r_busy;
    logic              r_cfg_err;
    logic [7:0]        r_pix_hold;
    logic [7:0]        w_pix;

    function automatic state_t first_state(input logic [9:0] hb, input logic [9:0] vb);
        if (vb != 10'd0)
            return S_VBLANK;
        else if (hb != 10'd0)
            return S_HBLANK;
        else
            return S_ACTIVE;
    endfunction

    // A vertical-blank line is split into an HB-long part and an AIP-long part
    // so the 10-bit pixel counter never has to reach HB+AIP.
    assign w_seg_last = r_vb_act ? (r_aip - 10'd1) : (r_hb - 10'd1);

    always_comb begin
        w_state_nxt    = r_state;
        w_pix_cnt_nxt  = r_pix_cnt;
        w_line_cnt_nxt = r_line_cnt;
        w_vb_act_nxt   = r_vb_act;
        w_addr_nxt     = r_addr;
        w_latch        = 1'b0;
        w_cfg_err      = 1'b0;
        w_frame_end    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !r_busy) begin
                    if (AIPOut_PD == 10'd0 || AILOut_PD == 10'd0) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_latch        = 1'b1;
                        w_state_nxt    = first_state(HBOut_PD, VBOut_PD);
                        w_pix_cnt_nxt  = 10'd0;
                        w_line_cnt_nxt = 10'd0;
                        w_vb_act_nxt   = (HBOut_PD == 10'd0);
                        w_addr_nxt     = '0;
                    end
                end
            end

            S_VBLANK: begin
                if (r_pix_cnt == w_seg_last) begin
                    w_pix_cnt_nxt = 10'd0;
                    if (!r_vb_act) begin
                        w_vb_act_nxt = 1'b1;
                    end else if (r_line_cnt == r_vb - 10'd1) begin
                        w_line_cnt_nxt = 10'd0;
                        w_state_nxt    = (r_hb == 10'd0) ? S_ACTIVE : S_HBLANK;
                    end else begin
                        w_line_cnt_nxt = r_line_cnt + 10'd1;
                        w_vb_act_nxt   = (r_hb == 10'd0);
                    end
                end else begin
                    w_pix_cnt_nxt = r_pix_cnt + 10'd1;
                end
            end

            S_HBLANK: begin
                if (r_pix_cnt == r_hb - 10'd1) begin
                    w_pix_cnt_nxt = 10'd0;
                    w_state_nxt   = S_ACTIVE;
                end else begin
                    w_pix_cnt_nxt = r_pix_cnt + 10'd1;
                end
            end

            S_ACTIVE: begin
                w_addr_nxt = r_addr + ADDR_W'(1);
                if (r_pix_cnt == r_aip - 10'd1) begin
                    w_pix_cnt_nxt = 10'd0;
                    if (r_line_cnt == r_ail - 10'd1) begin
                        w_frame_end    = 1'b1;
                        w_line_cnt_nxt = 10'd0;
                        w_addr_nxt     = '0;
                        if (CONTINUOUS) begin
                            w_state_nxt  = first_state(r_hb, r_vb);
                            w_vb_act_nxt = (r_hb == 10'd0);
                        end else begin
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        w_line_cnt_nxt = r_line_cnt + 10'd1;
                        w_state_nxt    = (r_hb == 10'd0) ? S_ACTIVE : S_HBLANK;
                    end
                end else begin
                    w_pix_cnt_nxt = r_pix_cnt + 10'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pix_cnt  <= 10'd0;
            r_line_cnt <= 10'd0;
            r_vb_act   <= 1'b0;
            r_addr     <= '0;
            r_hb       <= 10'd0;
            r_vb       <= 10'd0;
            r_aip      <= 10'd0;
            r_ail      <= 10'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pix_cnt  <= w_pix_cnt_nxt;
            r_line_cnt <= w_line_cnt_nxt;
            r_vb_act   <= w_vb_act_nxt;
            r_addr     <= w_addr_nxt;
            if (w_latch) begin
                r_hb  <= HBOut_PD;
                r_vb  <= VBOut_PD;
                r_aip <= AIPOut_PD;
                r_ail <= AILOut_PD;
            end
        end
    end

    // Flags trail the state by one cycle to line up with the read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_valid  <= 1'b0;
            r_hblank     <= 1'b0;
            r_vblank     <= 1'b0;
            r_line_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_pix_hold   <= 8'd0;
        end else begin
            r_pix_valid  <= (r_state == S_ACTIVE);
            r_hblank     <= (r_state == S_HBLANK);
            r_vblank     <= (r_state == S_VBLANK);
            r_line_start <= (r_state == S_ACTIVE) && (r_pix_cnt == 10'd0);
            r_frame_done <= w_frame_end;
            r_busy       <= (w_state_nxt != S_IDLE) || w_frame_end;
            r_cfg_err    <= w_cfg_err;
            r_pix_hold   <= w_pix;
        end
    end

    // Read data lands one cycle after the strobe, i.e. alongside PixValid.
    assign w_pix      = r_pix_valid ? FrameRData : r_pix_hold;

    assign FrameRd    = (r_state == S_ACTIVE);
    assign FrameRAddr = r_addr;
    assign PixOut     = w_pix;
    assign PixValid   = r_pix_valid;
    assign HBlank     = r_hblank;
    assign VBlank     = r_vblank;
    assign LineStart  = r_line_start;
    assign FrameDone  = r_frame_done;
    assign Busy       = r_busy;
    assign CfgErr     = r_cfg_err;

endmodule

`default_nettype wire
